// File: rtl/jpeg_bitpacker.sv
// JPEG entropy-coded segment bit writer: packs variable-length codes MSB-first, stuffs 0x00 after 0xFF,
// pads with 1s and emits 32-bit words with strobes/last. Define JPEG_BITPACK_EOI_EN to append an FF D9 marker.
module jpeg_bitpacker (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        img_start_i,
    input  logic        inport_valid_i,
    input  logic [15:0] inport_data_i,
    input  logic [4:0]  inport_width_i,
    input  logic        inport_last_i,
    output logic        inport_accept_o,
    output logic        outport_valid_o,
    output logic [31:0] outport_data_o,
    output logic [3:0]  outport_strb_o,
    output logic        outport_last_o,
    input  logic        outport_accept_i,
    output logic        idle_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAD   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
`ifdef JPEG_BITPACK_EOI_EN
    localparam logic [2:0] ST_EOI   = 3'd4;
`endif
    localparam logic [2:0] ST_FLUSH = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    function automatic logic [3:0] strb_for(input logic [2:0] n);
        case (n)
            3'd0:    strb_for = 4'b0000;
            3'd1:    strb_for = 4'b0001;
            3'd2:    strb_for = 4'b0011;
            3'd3:    strb_for = 4'b0111;
            default: strb_for = 4'b1111;
        endcase
    endfunction

    logic [2:0]  state_r, state_nxt_s;
    logic [23:0] acc_r, acc_nxt_s;
    logic [4:0]  bit_cnt_r, cnt_nxt_s;
    logic        stuff_r, stuff_nxt_s;
    logic [31:0] word_r, word_nxt_s, word_base_s;
    logic [2:0]  byte_cnt_r, byte_cnt_nxt_s, cnt_base_s;
    logic        accept_r, idle_r;
    logic        out_valid_r, out_last_r;
    logic [31:0] out_data_r;
    logic [3:0]  out_strb_r;
`ifdef JPEG_BITPACK_EOI_EN
    logic        eoi_idx_r;
`endif

    logic        take_s, active_s, out_free_s, move_s, slot_s;
    logic        ext_stuff_s, ext_data_s, eoi_wr_s, flush_s, wr_s;
    logic [7:0]  wr_byte_s;
    logic [4:0]  width_eff_s;
    logic [15:0] code_mask_s;
    logic [23:0] code_bits_s, pad_mask_s;
    logic [2:0]  pad_n_s;

    // Handshake qualifiers and selection of the byte written into the word register
    always_comb begin
        take_s      = inport_valid_i && accept_r;
        active_s    = (state_r != ST_IDLE) && (state_r != ST_DONE);
        out_free_s  = !out_valid_r || outport_accept_i;
        move_s      = active_s && (byte_cnt_r == 3'd4) && out_free_s;
        // a word leaving this cycle frees byte slot 0 for the next byte
        slot_s      = (byte_cnt_r < 3'd4) || move_s;
        ext_stuff_s = active_s && !take_s && slot_s && stuff_r;
        ext_data_s  = active_s && !take_s && slot_s && !stuff_r && (bit_cnt_r >= 5'd8);
        flush_s     = (state_r == ST_FLUSH) && (byte_cnt_r != 3'd4) && out_free_s;
        eoi_wr_s    = 1'b0;
`ifdef JPEG_BITPACK_EOI_EN
        eoi_wr_s    = (state_r == ST_EOI) && slot_s;
`endif
        wr_s        = ext_stuff_s || ext_data_s || eoi_wr_s;
        if (ext_stuff_s)
            wr_byte_s = 8'h00;
        else if (ext_data_s)
            wr_byte_s = acc_r[23:16];
`ifdef JPEG_BITPACK_EOI_EN
        else if (eoi_wr_s)
            wr_byte_s = eoi_idx_r ? 8'hD9 : 8'hFF;
`endif
        else
            wr_byte_s = 8'h00;
    end

    // Bit accumulator, stuff flag and word register next-state
    always_comb begin
        width_eff_s = (inport_width_i > 5'd16) ? 5'd16 : inport_width_i;
        code_mask_s = (width_eff_s == 5'd16) ? 16'hFFFF : ((16'h0001 << width_eff_s) - 16'h0001);
        code_bits_s = {8'h00, inport_data_i & code_mask_s};
        pad_n_s     = 3'd0 - bit_cnt_r[2:0];
        pad_mask_s  = ((24'h000001 << pad_n_s) - 24'h000001) << (5'd24 - bit_cnt_r - {2'b00, pad_n_s});
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = bit_cnt_r;
        if (take_s) begin
            acc_nxt_s = acc_r | (code_bits_s << (5'd24 - bit_cnt_r - width_eff_s));
            cnt_nxt_s = bit_cnt_r + width_eff_s;
        end else if (state_r == ST_PAD) begin
            acc_nxt_s = acc_r | pad_mask_s;
            cnt_nxt_s = bit_cnt_r + {2'b00, pad_n_s};
        end else begin
            acc_nxt_s = acc_r;
            cnt_nxt_s = bit_cnt_r;
        end
        if (ext_data_s) begin
            acc_nxt_s = acc_nxt_s << 8;
            cnt_nxt_s = cnt_nxt_s - 5'd8;
        end else begin
            acc_nxt_s = acc_nxt_s;
        end
        if (ext_stuff_s)
            stuff_nxt_s = 1'b0;
        else if (ext_data_s && (acc_r[23:16] == 8'hFF))
            stuff_nxt_s = 1'b1;
        else
            stuff_nxt_s = stuff_r;
        word_base_s    = move_s ? 32'h0000_0000 : word_r;
        cnt_base_s     = move_s ? 3'd0 : byte_cnt_r;
        word_nxt_s     = word_base_s;
        byte_cnt_nxt_s = cnt_base_s;
        if (wr_s) begin
            word_nxt_s[{cnt_base_s[1:0], 3'b000} +: 8] = wr_byte_s;
            byte_cnt_nxt_s = cnt_base_s + 3'd1;
        end else if (flush_s) begin
            word_nxt_s     = 32'h0000_0000;
            byte_cnt_nxt_s = 3'd0;
        end else begin
            word_nxt_s     = word_base_s;
            byte_cnt_nxt_s = cnt_base_s;
        end
    end

    // Scan sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = ST_IDLE;
            ST_RUN:   state_nxt_s = (take_s && inport_last_i) ? ST_PAD : ST_RUN;
            ST_PAD:   state_nxt_s = ST_DRAIN;
`ifdef JPEG_BITPACK_EOI_EN
            ST_DRAIN: state_nxt_s = ((bit_cnt_r == 5'd0) && !stuff_r) ? ST_EOI : ST_DRAIN;
            ST_EOI:   state_nxt_s = (eoi_wr_s && eoi_idx_r) ? ST_FLUSH : ST_EOI;
`else
            ST_DRAIN: state_nxt_s = ((bit_cnt_r == 5'd0) && !stuff_r) ? ST_FLUSH : ST_DRAIN;
`endif
            ST_FLUSH: state_nxt_s = flush_s ? ST_DONE : ST_FLUSH;
            ST_DONE:  state_nxt_s = (out_valid_r && outport_accept_i) ? ST_IDLE : ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State, datapath and output registers; img_start_i clears everything and starts a scan
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            acc_r       <= 24'h000000;
            bit_cnt_r   <= 5'd0;
            stuff_r     <= 1'b0;
            word_r      <= 32'h0000_0000;
            byte_cnt_r  <= 3'd0;
            accept_r    <= 1'b0;
            idle_r      <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            out_strb_r  <= 4'b0000;
            out_last_r  <= 1'b0;
        end else if (img_start_i) begin
            state_r     <= ST_RUN;
            acc_r       <= 24'h000000;
            bit_cnt_r   <= 5'd0;
            stuff_r     <= 1'b0;
            word_r      <= 32'h0000_0000;
            byte_cnt_r  <= 3'd0;
            accept_r    <= 1'b1;
            idle_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            out_strb_r  <= 4'b0000;
            out_last_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            acc_r      <= acc_nxt_s;
            bit_cnt_r  <= cnt_nxt_s;
            stuff_r    <= stuff_nxt_s;
            word_r     <= word_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            accept_r   <= (state_nxt_s == ST_RUN) && (cnt_nxt_s <= 5'd7);
            idle_r     <= (state_nxt_s == ST_IDLE);
            if (move_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= word_r;
                out_strb_r  <= 4'b1111;
                out_last_r  <= 1'b0;
            end else if (flush_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= word_r;
                out_strb_r  <= strb_for(byte_cnt_r);
                out_last_r  <= 1'b1;
            end else if (outport_accept_i) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

`ifdef JPEG_BITPACK_EOI_EN
    // Marker byte index: 0 writes 0xFF, 1 writes 0xD9
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            eoi_idx_r <= 1'b0;
        else if (img_start_i)
            eoi_idx_r <= 1'b0;
        else if (eoi_wr_s)
            eoi_idx_r <= ~eoi_idx_r;
        else
            eoi_idx_r <= eoi_idx_r;
    end
`endif

    assign inport_accept_o = accept_r;
    assign idle_o          = idle_r;
    assign outport_valid_o = out_valid_r;
    assign outport_data_o  = out_data_r;
    assign outport_strb_o  = out_strb_r;
    assign outport_last_o  = out_last_r;

endmodule

// File: tb/tb_jpeg_bitpacker.sv
// Scoreboard bench for jpeg_bitpacker: a bit-level reference model builds the expected word stream per scan.
module tb_jpeg_bitpacker;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        img_start_i = 1'b0;
    logic        inport_valid_i = 1'b0;
    logic [15:0] inport_data_i = 16'h0000;
    logic [4:0]  inport_width_i = 5'd0;
    logic        inport_last_i = 1'b0;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic [31:0] outport_data_o;
    logic [3:0]  outport_strb_o;
    logic        outport_last_o;
    logic        outport_accept_i = 1'b1;
    logic        idle_o;

    jpeg_bitpacker dut (
        .clk_i(clk_i), .rst_i(rst_i), .img_start_i(img_start_i),
        .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i),
        .inport_width_i(inport_width_i), .inport_last_i(inport_last_i),
        .inport_accept_o(inport_accept_o), .outport_valid_o(outport_valid_o),
        .outport_data_o(outport_data_o), .outport_strb_o(outport_strb_o),
        .outport_last_o(outport_last_o), .outport_accept_i(outport_accept_i),
        .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    int          extra_words = 0;
    int          bp_mode = 0;
    logic [36:0] exp_q[$];
    logic [15:0] cd_q[$];
    logic [4:0]  cw_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // sink ready: 0 always ready, 1 held off, 2 random
    always @(posedge clk_i) begin
        #1;
        case (bp_mode)
            1:       outport_accept_i = 1'b0;
            2:       outport_accept_i = ($urandom_range(0, 3) != 0);
            default: outport_accept_i = 1'b1;
        endcase
    end

    always @(negedge clk_i) begin
        if (rst_i && outport_valid_o && outport_accept_i) begin
            if (exp_q.size() == 0)
                extra_words++;
            else
                check_eq("word", {outport_last_o, outport_strb_o, outport_data_o}, exp_q.pop_front());
        end
    end

    task automatic model_scan();
        bit          bits[$];
        logic [7:0]  bytes[$];
        logic [7:0]  by;
        logic [31:0] data;
        logic [3:0]  strb;
        int          w;
        for (int i = 0; i < cd_q.size(); i++) begin
            w = (cw_q[i] > 5'd16) ? 16 : int'(cw_q[i]);
            for (int b = w - 1; b >= 0; b--) bits.push_back(cd_q[i][b]);
        end
        while (bits.size() % 8 != 0) bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i += 8) begin
            for (int b = 0; b < 8; b++) by[7-b] = bits[i+b];
            bytes.push_back(by);
            if (by == 8'hFF) bytes.push_back(8'h00);
        end
`ifdef JPEG_BITPACK_EOI_EN
        bytes.push_back(8'hFF);
        bytes.push_back(8'hD9);
`endif
        while (bytes.size() >= 4) begin
            for (int k = 0; k < 4; k++) data[8*k +: 8] = bytes.pop_front();
            exp_q.push_back({1'b0, 4'b1111, data});
        end
        data = 32'h0;
        strb = 4'b0000;
        for (int k = 0; k < bytes.size(); k++) begin
            data[8*k +: 8] = bytes[k];
            strb[k] = 1'b1;
        end
        exp_q.push_back({1'b1, strb, data});
    endtask

    task automatic pulse_start();
        img_start_i = 1'b1;
        @(posedge clk_i); #1;
        img_start_i = 1'b0;
    endtask

    task automatic send_code(input logic [15:0] d, input logic [4:0] w, input bit last);
        int t = 0;
        inport_valid_i = 1'b1;
        inport_data_i  = d;
        inport_width_i = w;
        inport_last_i  = last;
        while (1) begin
            @(negedge clk_i);
            if (inport_accept_o) break;
            t++;
            if (t > 300) begin
                check_eq("accept_timeout", t, 0);
                break;
            end
        end
        @(posedge clk_i); #1;
        inport_valid_i = 1'b0;
        inport_last_i  = 1'b0;
    endtask

    task automatic drive_codes();
        for (int i = 0; i < cd_q.size(); i++) send_code(cd_q[i], cw_q[i], i == cd_q.size() - 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!(idle_o && exp_q.size() == 0) && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        check_eq("scan_pending", exp_q.size(), 0);
        check_eq("scan_idle", idle_o, 1);
        cd_q.delete();
        cw_q.delete();
    endtask

    task automatic run_scan(input bit do_start);
        model_scan();
        if (do_start) pulse_start();
        drive_codes();
        wait_done();
    endtask

    task automatic add(input logic [15:0] d, input logic [4:0] w);
        cd_q.push_back(d);
        cw_q.push_back(w);
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!outport_valid_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        check_eq(tag, outport_valid_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_eq("rst_accept", inport_accept_o, 0);
        check_eq("rst_valid", outport_valid_o, 0);
        check_eq("rst_data", outport_data_o, 0);
        check_eq("rst_strb", outport_strb_o, 0);
        check_eq("rst_last", outport_last_o, 0);
        check_eq("rst_idle", idle_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        add(16'h0005, 5'd3);  add(16'h001F, 5'd5);  run_scan(1'b1);
        add(16'h00FF, 5'd8);  add(16'h0012, 5'd8);  run_scan(1'b1);
        add(16'h0000, 5'd1);  run_scan(1'b1);
        add(16'h0001, 5'd1);  run_scan(1'b1);
        add(16'h00A5, 5'd8);  run_scan(1'b1);
        // zero width, junk above width, and over-wide codes
        add(16'h1234, 5'd0);  add(16'hF0F5, 5'd4);  add(16'hABCD, 5'd20);
        add(16'hFFFF, 5'd31); add(16'h0007, 5'd3);  run_scan(1'b1);

        for (int i = 0; i < 8; i++) add(16'hABCD, 5'd16);
        model_scan();
        bp_mode = 1;
        pulse_start();
        fork
            drive_codes();
            begin
                wait_valid("bp_first_valid");
                check_eq("bp_first_data", outport_data_o, exp_q[0][31:0]);
                repeat (40) @(negedge clk_i);
                check_eq("bp_in_accept", inport_accept_o, 0);
                check_eq("bp_valid_held", outport_valid_o, 1);
                check_eq("bp_data_held", outport_data_o, exp_q[0][31:0]);
                check_eq("bp_strb_held", outport_strb_o, 4'b1111);
                bp_mode = 0;
            end
        join
        wait_done();

        for (int s = 0; s < 4; s++) begin
            int n = $urandom_range(5, 20);
            for (int i = 0; i < n; i++) add(16'($urandom), 5'($urandom_range(0, 20)));
            bp_mode = 2;
            run_scan(1'b1);
            bp_mode = 0;
            @(posedge clk_i); #1;
        end

        bp_mode = 1;
        pulse_start();
        for (int i = 0; i < 3; i++) send_code(16'hABCD, 5'd16, 1'b0);
        wait_valid("abort_pre_valid");
        @(posedge clk_i); #1;
        img_start_i = 1'b1;
        @(posedge clk_i); #1;
        img_start_i = 1'b0;
        bp_mode = 0;
        @(negedge clk_i);
        check_eq("abort_valid", outport_valid_o, 0);
        @(posedge clk_i); #1;
        add(16'h003C, 5'd8);  run_scan(1'b0);

        bp_mode = 1;
        pulse_start();
        for (int i = 0; i < 3; i++) send_code(16'hABCD, 5'd16, 1'b0);
        wait_valid("rst_pre_valid");
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        bp_mode = 0;
        @(negedge clk_i);
        check_eq("rst_abort_valid", outport_valid_o, 0);
        check_eq("rst_abort_idle", idle_o, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        add(16'h003C, 5'd8);  run_scan(1'b1);

        repeat (5) @(posedge clk_i);
        check_eq("extra_words", extra_words, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jpeg_bitpacker.md
# jpeg_bitpacker

Entropy-coded segment bit writer for the JPEG encode path: the transmit-side counterpart of the decoder's bit buffer. It accepts variable-length codes of up to 16 bits, packs them MSB-first into bytes and inserts a 0x00 stuff byte after every 0xFF. At end of scan it pads to a byte boundary with 1s and emits 32-bit words with byte strobes and last in the same format the decoder's input port consumes. It sits between the Huffman/MCU encoder and the output stream DMA.

## Interface
- No parameters.
- clk_i  input  1  clock, all flops rising-edge.
- rst_i  input  1  asynchronous active-low reset.
- img_start_i  input  1  one-cycle pulse: start of scan; clears all state, including any pending output.
- inport_valid_i  input  1  code valid.
- inport_data_i  input  16  code bits, right-aligned; bits at and above width ignored.
- inport_width_i  input  5  code length 0..16; 0 = no bits; values >16 treated as 16.
- inport_last_i  input  1  final code of scan; flush follows.
- inport_accept_o  output  1  code taken when valid && accept.
- outport_valid_o  output  1  output word valid.
- outport_data_o  output  32  stream bytes; first byte in [7:0].
- outport_strb_o  output  4  byte enables, contiguous from bit 0; 0000 allowed only on last word.
- outport_last_o  output  1  final word of scan.
- outport_accept_i  input  1  sink ready.
- idle_o  output  1  high in IDLE.

## Operation
- Datapath: bit accumulator acc[23:0] with bit_cnt 0..23, valid bits left-justified. Pending-stuff flag. Word register word_q[31:0] with byte_cnt 0..4. Output register.
- States: IDLE, RUN, PAD, DRAIN, EOI (macro only), FLUSH, DONE.
- IDLE: accept=0, idle_o=1. img_start_i -> RUN.
- RUN: inport_accept_o = (bit_cnt <= 7). Accepted code appended below existing bits; bit_cnt += width. Accepted code with last -> PAD.
- Extraction, any state except IDLE/DONE, one byte per cycle, only when no code is accepted that cycle and byte_cnt < 4: if the stuff flag is set, write 0x00 and clear the flag. Else, if bit_cnt >= 8, write acc top byte and set bit_cnt -= 8; a byte equal to 0xFF sets the stuff flag.
- Word register: when byte_cnt == 4 and the output register is empty or being accepted, move the word to the output register with strb=1111 and last=0.
- PAD: if bit_cnt % 8 != 0, fill 1s to the next byte boundary in one cycle. Then -> DRAIN.
- DRAIN: wait until bit_cnt == 0 and the stuff flag is clear. Then -> EOI if the macro is compiled in, else -> FLUSH.
- EOI: write 0xFF then 0xD9 to the word register, with no stuffing. Then -> FLUSH.
- FLUSH: when the output register is free, move word_q with strb = (1<<byte_cnt)-1 and last=1. This happens even when byte_cnt == 0 (strb 0000). Then -> DONE.
- DONE: when the last word is accepted -> IDLE.
- img_start_i in any state: same effect as reset, then -> RUN.
- The output register holds data, strb and last stable while valid && !accept.

## Timing
- Reset values: inport_accept_o=0, outport_valid_o=0, outport_data_o=0, outport_strb_o=0, outport_last_o=0, idle_o=1. All internal counters and flags are 0.
- Code accepted in cycle N: acc updated at edge N+1; byte written to word_q at edge N+2; if this is the 4th byte, outport_valid_o is high from cycle N+3.
- Accept and extraction never occur in the same cycle.
- Backpressure: when the output register is held and word_q is full, extraction stops and bit_cnt rises until accept falls. No code or byte is lost.
- Sustained 16-bit code rate: one code per 2-3 cycles.
- Minimum end-of-scan: last accepted code to outport_last_o is 4 cycles with the sink always ready.

## Configuration
- JPEG_BITPACK_EOI_EN: when defined, the EOI state appends marker bytes 0xFF 0xD9 (unstuffed) after the padded data, before the last word.
- Without the macro, the EOI state is absent; the stream ends with the padded entropy data only.

## Test plan
- Pack/basic (macro off): codes 0b101/w3, then 0b11111/w5 last -> one word: data 0x000000BF, strb 0001, last=1.
- Stuffing: 0xFF/w8, then 0x12/w8 last -> data 0x001200FF, strb 0111, last=1.
- Padding: 0b0/w1 last -> 0x0000007F, strb 0001. Also 0b1/w1 last -> bytes FF 00, strb 0011.
- Backpressure: 8× 0xABCD/w16 with outport_accept_i low for 40 cycles. Required: inport_accept_o low; first word 0xCDABCDAB held stable. On release: 4 words 0xCDABCDAB, then a zero-strobe last word.
- EOI (macro on): 0xA5/w8 last -> data 0x00D9FFA5, strb 0111, last=1.
- Abort: img_start_i mid-scan with outport_valid_o high. Required: valid=0 next cycle; a new scan 0x3C/w8 last yields 0x0000003C, strb 0001. Repeat with rst_i low for the same outcome.
